decoder_scan_sequencer: RTL and testbench

Upstream driver for the 4x16 decoder: it walks a 16-entry channel mask and presents each enabled channel as a 4-bit select plus an enable strobe, directly on the decoder's `i[3:0]` and `en` inputs. Each channel is held for a programmable dwell time. A one-cycle break-before-make gap separates channels so that two decoder outputs are never active on adjacent cycles. Scans run once or loop continuously, and can be aborted at any time.

---
 rtl/decoder_scan_sequencer_if.sv | 27 ++
 rtl/decoder_scan_sequencer.sv | 147 ++++++++++++++
 tb/tb_decoder_scan_sequencer.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/decoder_scan_sequencer_if.sv
// Handshake/bus bundle between a scan controller and decoder_scan_sequencer.
// The master side owns the scan request and configuration; the slave side
// (the sequencer) drives the decoder select/enable and the status pulses.
interface decoder_scan_sequencer_if #(
  parameter int DWELL_W = 8
);
  logic               start;
  logic               stop;
  logic               cont;
  logic [DWELL_W-1:0] dwell;
  logic [15:0]        mask;
  logic [3:0]         sel;
  logic               en;
  logic               busy;
  logic               wrap;
  logic               done;

  modport master (
    output start, stop, cont, dwell, mask,
    input  sel, en, busy, wrap, done
  );

  modport slave (
    input  start, stop, cont, dwell, mask,
    output sel, en, busy, wrap, done
  );
endinterface

// File: rtl/decoder_scan_sequencer.sv
// Walks a 16-entry channel mask and drives a 4x16 decoder's select/enable.
// Each enabled channel is held for max(dwell,1) cycles, followed by a single
// break-before-make gap cycle so no two decoder outputs are active on
// adjacent cycles. Scans run once or loop, and can be aborted at any time.
module decoder_scan_sequencer #(
  parameter int DWELL_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  decoder_scan_sequencer_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_GAP, S_DONE} state_t;

  state_t             state;
  logic [DWELL_W-1:0] cnt;
  logic [DWELL_W-1:0] dwell_lat;
  logic [15:0]        mask_lat;
  logic               cont_lat;
  logic [3:0]         sel_r;
  logic               en_r;
  logic               busy_r;
  logic               wrap_r;
  logic               done_r;
  logic               take_start;
  logic [4:0]         next_hit;
  logic [3:0]         first_lat;

  // A dwell of zero would otherwise produce an empty ACTIVE phase.
  function automatic logic [DWELL_W-1:0] clamp_dwell(input logic [DWELL_W-1:0] d);
    return (d == '0) ? DWELL_W'(1) : d;
  endfunction

  // Index of the lowest set bit; 0 when the mask is empty.
  function automatic logic [3:0] first_set(input logic [15:0] m);
    logic [3:0] r;
    r = 4'd0;
    for (int k = 15; k >= 0; k--) begin
      if (m[k]) r = 4'(k);
    end
    return r;
  endfunction

  // {found, index} of the lowest set bit strictly above cur.
  function automatic logic [4:0] next_above(input logic [15:0] m, input logic [3:0] cur);
    logic [4:0] r;
    r = 5'd0;
    for (int k = 15; k >= 0; k--) begin
      if (m[k] && (5'(k) > {1'b0, cur})) r = {1'b1, 4'(k)};
    end
    return r;
  endfunction

  assign take_start = (state == S_IDLE) && bus.start && !bus.stop;
  assign next_hit   = next_above(mask_lat, sel_r);
  assign first_lat  = first_set(mask_lat);

  // Scan configuration is captured only when a scan is actually accepted.
  always_ff @(posedge clk) begin
    if (take_start) begin
      mask_lat  <= bus.mask;
      dwell_lat <= clamp_dwell(bus.dwell);
      cont_lat  <= bus.cont;
    end
  end

  // Scan state machine with registered decoder and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      sel_r  <= 4'd0;
      en_r   <= 1'b0;
      busy_r <= 1'b0;
      wrap_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      wrap_r <= 1'b0;
      done_r <= 1'b0;
      case (state)
        S_IDLE: begin
          if (take_start) begin
            if (bus.mask != 16'd0) begin
              state  <= S_ACTIVE;
              sel_r  <= first_set(bus.mask);
              cnt    <= clamp_dwell(bus.dwell);
              en_r   <= 1'b1;
              busy_r <= 1'b1;
            end else begin
              state  <= S_DONE;
              done_r <= 1'b1;
            end
          end
        end
        S_ACTIVE: begin
          if (bus.stop) begin
            state  <= S_IDLE;
            en_r   <= 1'b0;
            busy_r <= 1'b0;
          end else if (cnt <= DWELL_W'(1)) begin
            state <= S_GAP;
            en_r  <= 1'b0;
          end else begin
            cnt <= cnt - DWELL_W'(1);
          end
        end
        S_GAP: begin
          if (bus.stop) begin
            state  <= S_IDLE;
            busy_r <= 1'b0;
          end else if (next_hit[4]) begin
            state <= S_ACTIVE;
            sel_r <= next_hit[3:0];
            cnt   <= dwell_lat;
            en_r  <= 1'b1;
          end else if (cont_lat) begin
            state  <= S_ACTIVE;
            sel_r  <= first_lat;
            cnt    <= dwell_lat;
            en_r   <= 1'b1;
            wrap_r <= 1'b1;
          end else begin
            state  <= S_DONE;
            busy_r <= 1'b0;
            done_r <= 1'b1;
          end
        end
        S_DONE: begin
          // The done pulse lasts exactly this cycle, stop or not.
          state <= S_IDLE;
        end
        default: begin
          state  <= S_IDLE;
          en_r   <= 1'b0;
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.sel  = sel_r;
  assign bus.en   = en_r;
  assign bus.busy = busy_r;
  assign bus.wrap = wrap_r;
  assign bus.done = done_r;

endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// Bench for decoder_scan_sequencer: directed vector table, hand-written
// corner sequences, and randomized scans against a cycle-index model.
module tb_decoder_scan_sequencer;

  localparam int DWELL_W = 8;

  typedef struct packed {
    logic [3:0] sel;
    logic       en;
    logic       busy;
    logic       wrap;
    logic       done;
  } outs_t;

  typedef struct {
    logic [15:0] mask;
    int          dwell;
    bit          cont;
    int          cyc;
    outs_t       exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic [3:0] tb_sel = 4'd0;
  vec_t tbl[16];

  always #5 clk = ~clk;

  decoder_scan_sequencer_if #(.DWELL_W(DWELL_W)) bus();

  decoder_scan_sequencer #(.DWELL_W(DWELL_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  function automatic outs_t mk(input int s, input bit e, input bit b, input bit w, input bit d);
    return {4'(s), e, b, w, d};
  endfunction

  function automatic outs_t cur();
    return {bus.sel, bus.en, bus.busy, bus.wrap, bus.done};
  endfunction

  // Expected outputs in cycle k of a scan started in cycle 0, no abort.
  // Channel slots of length dwell+1 are laid end to end from cycle 1.
  function automatic outs_t model(input logic [15:0] m, input int dw, input bit c,
                                  input int k, input logic [3:0] sel0);
    int    ch[$];
    int    n, d, p, idx, ph;
    outs_t o;
    o = mk(int'(sel0), 0, 0, 0, 0);
    for (int b = 0; b < 16; b++) if (m[b]) ch.push_back(b);
    n = ch.size();
    d = (dw < 1) ? 1 : dw;
    p = d + 1;
    if (k < 1) return o;
    if (n == 0) begin
      o.done = (k == 1);
      return o;
    end
    idx = (k - 1) / p;
    ph  = (k - 1) % p;
    if (!c && idx >= n) begin
      o.sel  = 4'(ch[n-1]);
      o.done = (k == n * p + 1);
      return o;
    end
    o.sel  = 4'(ch[idx % n]);
    o.en   = (ph < d);
    o.busy = 1'b1;
    o.wrap = c && (ph == 0) && (idx > 0) && (idx % n == 0);
    return o;
  endfunction

  // Same, with an abort raised during cycle s (s = 0: never).
  function automatic outs_t expected(input logic [15:0] m, input int dw, input bit c,
                                     input int k, input int s, input logic [3:0] sel0);
    outs_t o;
    if (s > 0 && k > s) begin
      o = model(m, dw, c, s, sel0);
      return mk(int'(o.sel), 0, 0, 0, 0);
    end
    return model(m, dw, c, k, sel0);
  endfunction

  task automatic check(input string name, input int k, input outs_t act, input outs_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got sel=%0d en=%b busy=%b wrap=%b done=%b, expected sel=%0d en=%b busy=%b wrap=%b done=%b",
               name, k, act.sel, act.en, act.busy, act.wrap, act.done,
               exp.sel, exp.en, exp.busy, exp.wrap, exp.done);
    end
  endtask

  task automatic drive_start(input logic [15:0] m, input int dw, input bit c);
    bus.start = 1'b1;
    bus.stop  = 1'b0;
    bus.mask  = m;
    bus.dwell = DWELL_W'(dw);
    bus.cont  = c;
  endtask

  // One scan from IDLE, checked every cycle; optional garbage on the config
  // inputs and spurious start pulses while the scan is in progress.
  task automatic run_scan(input logic [15:0] m, input int dw, input bit c,
                          input int ncyc, input int s, input bit garble);
    outs_t e;
    drive_start(m, dw, c);
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      e = expected(m, dw, c, k, s, tb_sel);
      check("rand_scan", k, cur(), e);
      bus.start = 1'b0;
      bus.stop  = (k == s);
      if (garble) begin
        bus.mask  = 16'($urandom);
        bus.dwell = DWELL_W'($urandom);
        bus.cont  = 1'($urandom);
        if ((s == 0 || k < s) && (e.busy || e.done) && $urandom_range(0, 3) == 0)
          bus.start = 1'b1;
      end
    end
    tb_sel    = expected(m, dw, c, ncyc, s, tb_sel).sel;
    bus.start = 1'b0;
    bus.stop  = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    outs_t o;
    int    dn;

    tbl[0]  = '{16'h0000, 3, 1'b0, 1,  mk(0, 0, 0, 0, 1)};
    tbl[1]  = '{16'h0005, 3, 1'b0, 1,  mk(0, 1, 1, 0, 0)};
    tbl[2]  = '{16'h0005, 3, 1'b0, 3,  mk(0, 1, 1, 0, 0)};
    tbl[3]  = '{16'h0005, 3, 1'b0, 4,  mk(0, 0, 1, 0, 0)};
    tbl[4]  = '{16'h0005, 3, 1'b0, 5,  mk(2, 1, 1, 0, 0)};
    tbl[5]  = '{16'h0005, 3, 1'b0, 7,  mk(2, 1, 1, 0, 0)};
    tbl[6]  = '{16'h0005, 3, 1'b0, 8,  mk(2, 0, 1, 0, 0)};
    tbl[7]  = '{16'h0005, 3, 1'b0, 9,  mk(2, 0, 0, 0, 1)};
    tbl[8]  = '{16'h0005, 3, 1'b0, 10, mk(2, 0, 0, 0, 0)};
    tbl[9]  = '{16'h8001, 0, 1'b1, 1,  mk(0, 1, 1, 0, 0)};
    tbl[10] = '{16'h8001, 0, 1'b1, 2,  mk(0, 0, 1, 0, 0)};
    tbl[11] = '{16'h8001, 0, 1'b1, 3,  mk(15, 1, 1, 0, 0)};
    tbl[12] = '{16'h8001, 0, 1'b1, 5,  mk(0, 1, 1, 1, 0)};
    tbl[13] = '{16'h8001, 0, 1'b1, 6,  mk(0, 0, 1, 0, 0)};
    tbl[14] = '{16'h0010, 2, 1'b1, 3,  mk(4, 0, 1, 0, 0)};
    tbl[15] = '{16'h0010, 2, 1'b1, 4,  mk(4, 1, 1, 1, 0)};

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    bus.cont  = 1'b0;
    bus.dwell = '0;
    bus.mask  = '0;
    repeat (2) @(negedge clk);
    check("reset_values", 0, cur(), mk(0, 0, 0, 0, 0));
    rst = 1'b0;

    // Directed vectors: fresh start, probe one cycle, abort.
    for (int i = 0; i < 16; i++) begin
      drive_start(tbl[i].mask, tbl[i].dwell, tbl[i].cont);
      for (int k = 1; k <= tbl[i].cyc; k++) begin
        @(negedge clk);
        bus.start = 1'b0;
        if (k == tbl[i].cyc) check("vector", k, cur(), tbl[i].exp);
      end
      bus.stop = 1'b1;
      @(negedge clk);
      bus.stop = 1'b0;
    end
    tb_sel = tbl[15].exp.sel;

    // Randomized scans.
    for (int r = 0; r < 40; r++) begin
      logic [15:0] m;
      int dw, n, p, s, ncyc;
      bit c;
      case ($urandom_range(0, 7))
        0:       m = 16'h0000;
        1, 2:    m = 16'h1 << $urandom_range(0, 15);
        3, 4:    m = 16'($urandom & $urandom & $urandom);
        default: m = 16'($urandom);
      endcase
      dw = $urandom_range(0, 4);
      c  = 1'($urandom);
      n  = $countones(m);
      p  = ((dw < 1) ? 1 : dw) + 1;
      if (c) s = $urandom_range(1, 2 * n * p + 3);
      else   s = ($urandom_range(0, 1) == 1) ? $urandom_range(1, n * p + 2) : 0;
      ncyc = (s > 0) ? s + 2 : n * p + 3;
      run_scan(m, dw, c, ncyc, s, 1'b1);
    end

    // Synchronous-window reset pulse returns everything to zero.
    @(negedge clk);
    rst = 1'b1;
    #1 check("reset_pulse", 0, cur(), mk(0, 0, 0, 0, 0));
    @(negedge clk);
    rst    = 1'b0;
    tb_sel = 4'd0;

    // start and stop together in IDLE: nothing happens.
    drive_start(16'hFFFF, 2, 1'b0);
    bus.stop = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check("start_stop_collision", k, cur(), mk(0, 0, 0, 0, 0));
    end
    bus.start = 1'b0;
    bus.stop  = 1'b0;

    // Abort mid-dwell, then restart from the lowest channel.
    drive_start(16'hFFFF, 10, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      check("stop_mid_dwell", k, cur(), (k <= 4) ? mk(0, 1, 1, 0, 0) : mk(0, 0, 0, 0, 0));
      bus.stop = (k == 4);
    end
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("restart_after_stop", 1, cur(), mk(0, 1, 1, 0, 0));
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
    check("stop_again", 2, cur(), mk(0, 0, 0, 0, 0));

    // Config latched at start; start during ACTIVE ignored.
    drive_start(16'h0002, 2, 1'b0);
    dn = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      case (k)
        1, 2:    o = mk(1, 1, 1, 0, 0);
        3:       o = mk(1, 0, 1, 0, 0);
        4:       o = mk(1, 0, 0, 0, 1);
        default: o = mk(1, 0, 0, 0, 0);
      endcase
      check("latch_config", k, cur(), o);
      if (bus.done === 1'b1) dn++;
      bus.mask  = 16'hFFFF;
      bus.dwell = DWELL_W'(5);
      bus.cont  = 1'b1;
      bus.start = (k < 3);
    end
    checks++;
    if (dn != 1) begin
      errors++;
      $display("FAIL done_pulse_count: got %0d, expected 1", dn);
    end

    // Asynchronous reset between edges during ACTIVE.
    drive_start(16'h0100, 10, 1'b1);
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      check("pre_async_reset", k, cur(), mk(8, 1, 1, 0, 0));
    end
    #2 rst = 1'b1;
    #1 check("async_reset", 3, cur(), mk(0, 0, 0, 0, 0));
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check("idle_after_reset", k, cur(), mk(0, 0, 0, 0, 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
